id_ex_operand_stage: RTL and testbench

- Sits between the decoder and the execute unit; directly consumes the register file read ports and watches its write port.
- Resolves operand values at ID->EX transfer:
  - WB bypass, needed because the register file reads the pre-write value during a write cycle.
  - MEM-stage forwarding.
  - EX-ahead forward flags.
- Detects load-use hazards and inserts bubbles.
- Holds the ID/EX pipeline register, with a valid/ready handshake on both sides.

---
 rtl/id_ex_operand_stage.sv | 181 ++++++++++++++++++
 tb/tb_id_ex_operand_stage.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_operand_stage.sv
`default_nettype none
// ============================================================================
//  Module   : id_ex_operand_stage
//  Purpose  : ID->EX operand resolution (WB bypass, MEM forward, EX-ahead
//             flags), load-use bubbling and the ID/EX pipeline register.
//             Optional stall counter: define ID_EX_STALL_COUNTER_EN.
//  Revision : 1.0  initial release
// ============================================================================
module id_ex_operand_stage #(
    parameter int XLEN   = 32,
    parameter int CTRL_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    output logic              id_ready,
    input  logic [4:0]        id_rs1,
    input  logic [4:0]        id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [4:0]        id_rd,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic [XLEN-1:0]   id_imm,
    input  logic [XLEN-1:0]   id_pc,
    output logic [4:0]        rf_rs1,
    output logic [4:0]        rf_rs2,
    input  logic [XLEN-1:0]   rf_rdata1,
    input  logic [XLEN-1:0]   rf_rdata2,
    input  logic              wb_wen,
    input  logic [4:0]        wb_rd,
    input  logic [XLEN-1:0]   wb_data,
    input  logic              mem_wen,
    input  logic [4:0]        mem_rd,
    input  logic              mem_data_valid,
    input  logic [XLEN-1:0]   mem_data,
    input  logic              flush,
    input  logic              ex_ready,
    output logic              ex_valid,
    output logic [XLEN-1:0]   ex_op_a,
    output logic [XLEN-1:0]   ex_op_b,
    output logic              ex_fwd_a,
    output logic              ex_fwd_b,
    output logic [4:0]        ex_rd,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic [XLEN-1:0]   ex_imm,
    output logic [XLEN-1:0]   ex_pc,
    output logic [31:0]       stall_cnt
);

    localparam logic [4:0] c_X0 = 5'd0;

    logic              r_ex_valid;
    logic [XLEN-1:0]   r_ex_op_a;
    logic [XLEN-1:0]   r_ex_op_b;
    logic              r_ex_fwd_a;
    logic              r_ex_fwd_b;
    logic [4:0]        r_ex_rd;
    logic              r_ex_reg_write;
    logic              r_ex_mem_read;
    logic [CTRL_W-1:0] r_ex_ctrl;
    logic [XLEN-1:0]   r_ex_imm;
    logic [XLEN-1:0]   r_ex_pc;

    logic              w_haz_a;
    logic              w_haz_b;
    logic              w_fwd_a;
    logic              w_fwd_b;
    logic [XLEN-1:0]   w_op_a;
    logic [XLEN-1:0]   w_op_b;
    logic              w_hazard;
    logic              w_advance;
    logic              w_accept;

    // Returns {hazard, fwd, operand}; youngest producer wins, x0 never matches.
    function automatic logic [XLEN+1:0] resolve(
        input logic            use_s,
        input logic [4:0]      s,
        input logic [XLEN-1:0] rdata
    );
        logic            haz;
        logic            fwd;
        logic [XLEN-1:0] op;
        haz = 1'b0;
        fwd = 1'b0;
        op  = '0;
        if (use_s && (s != c_X0)) begin
            if (r_ex_valid && r_ex_reg_write && (r_ex_rd == s)) begin
                if (r_ex_mem_read) haz = 1'b1;
                else               fwd = 1'b1;
            end else if (mem_wen && (mem_rd == s)) begin
                if (mem_data_valid) op  = mem_data;
                else                haz = 1'b1;
            end else if (wb_wen && (wb_rd == s)) begin
                op = wb_data;
            end else begin
                op = rdata;
            end
        end
        return {haz, fwd, op};
    endfunction

    always_comb begin
        {w_haz_a, w_fwd_a, w_op_a} = resolve(id_use_rs1, id_rs1, rf_rdata1);
        {w_haz_b, w_fwd_b, w_op_b} = resolve(id_use_rs2, id_rs2, rf_rdata2);
    end

    assign w_hazard  = id_valid & (w_haz_a | w_haz_b);
    assign w_advance = ~r_ex_valid | ex_ready;
    assign w_accept  = id_valid & ~w_hazard;

    assign id_ready  = flush | (w_advance & ~w_hazard);
    assign rf_rs1    = id_rs1;
    assign rf_rs2    = id_rs2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex_valid     <= 1'b0;
            r_ex_op_a      <= '0;
            r_ex_op_b      <= '0;
            r_ex_fwd_a     <= 1'b0;
            r_ex_fwd_b     <= 1'b0;
            r_ex_rd        <= '0;
            r_ex_reg_write <= 1'b0;
            r_ex_mem_read  <= 1'b0;
            r_ex_ctrl      <= '0;
            r_ex_imm       <= '0;
            r_ex_pc        <= '0;
        end else if (flush) begin
            r_ex_valid <= 1'b0;
        end else if (w_advance) begin
            r_ex_valid <= w_accept;
            // Bubbles leave the payload untouched; only ex_valid matters then.
            if (w_accept) begin
                r_ex_op_a      <= w_op_a;
                r_ex_op_b      <= w_op_b;
                r_ex_fwd_a     <= w_fwd_a;
                r_ex_fwd_b     <= w_fwd_b;
                r_ex_rd        <= id_rd;
                r_ex_reg_write <= id_reg_write;
                r_ex_mem_read  <= id_mem_read;
                r_ex_ctrl      <= id_ctrl;
                r_ex_imm       <= id_imm;
                r_ex_pc        <= id_pc;
            end
        end
    end

`ifdef ID_EX_STALL_COUNTER_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (w_hazard && !flush) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`else
    assign stall_cnt = '0;
`endif

    assign ex_valid     = r_ex_valid;
    assign ex_op_a      = r_ex_op_a;
    assign ex_op_b      = r_ex_op_b;
    assign ex_fwd_a     = r_ex_fwd_a;
    assign ex_fwd_b     = r_ex_fwd_b;
    assign ex_rd        = r_ex_rd;
    assign ex_reg_write = r_ex_reg_write;
    assign ex_mem_read  = r_ex_mem_read;
    assign ex_ctrl      = r_ex_ctrl;
    assign ex_imm       = r_ex_imm;
    assign ex_pc        = r_ex_pc;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_operand_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_id_ex_operand_stage
//  Purpose  : Directed plus random checks of id_ex_operand_stage against a
//             producer-list reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_id_ex_operand_stage;
    localparam int XLEN   = 32;
    localparam int CTRL_W = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n;
    logic              id_valid, id_ready;
    logic [4:0]        id_rs1, id_rs2, id_rd;
    logic              id_use_rs1, id_use_rs2, id_reg_write, id_mem_read;
    logic [CTRL_W-1:0] id_ctrl;
    logic [XLEN-1:0]   id_imm, id_pc;
    logic [4:0]        rf_rs1, rf_rs2;
    logic [XLEN-1:0]   rf_rdata1, rf_rdata2;
    logic              wb_wen;
    logic [4:0]        wb_rd;
    logic [XLEN-1:0]   wb_data;
    logic              mem_wen, mem_data_valid;
    logic [4:0]        mem_rd;
    logic [XLEN-1:0]   mem_data;
    logic              flush, ex_ready, ex_valid;
    logic [XLEN-1:0]   ex_op_a, ex_op_b, ex_imm, ex_pc;
    logic              ex_fwd_a, ex_fwd_b, ex_reg_write, ex_mem_read;
    logic [4:0]        ex_rd;
    logic [CTRL_W-1:0] ex_ctrl;
    logic [31:0]       stall_cnt;

    id_ex_operand_stage #(.XLEN(XLEN), .CTRL_W(CTRL_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_ready(id_ready),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .id_ctrl(id_ctrl), .id_imm(id_imm), .id_pc(id_pc),
        .rf_rs1(rf_rs1), .rf_rs2(rf_rs2),
        .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
        .wb_wen(wb_wen), .wb_rd(wb_rd), .wb_data(wb_data),
        .mem_wen(mem_wen), .mem_rd(mem_rd),
        .mem_data_valid(mem_data_valid), .mem_data(mem_data),
        .flush(flush), .ex_ready(ex_ready), .ex_valid(ex_valid),
        .ex_op_a(ex_op_a), .ex_op_b(ex_op_b),
        .ex_fwd_a(ex_fwd_a), .ex_fwd_b(ex_fwd_b),
        .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_ctrl(ex_ctrl), .ex_imm(ex_imm), .ex_pc(ex_pc),
        .stall_cnt(stall_cnt)
    );

    int total = 0;
    int bad   = 0;

    // Reference model of what EX should hold.
    logic              m_valid, m_rw, m_mr, m_fwd_a, m_fwd_b;
    logic [4:0]        m_rd;
    logic [CTRL_W-1:0] m_ctrl;
    logic [XLEN-1:0]   m_op_a, m_op_b, m_imm, m_pc;
    logic [31:0]       m_cnt;

    typedef struct {
        logic            hit;
        logic            stall;
        logic            fwd;
        logic [XLEN-1:0] val;
    } prod_t;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_valid = 0; m_rw = 0; m_mr = 0; m_fwd_a = 0; m_fwd_b = 0;
        m_rd = 0; m_ctrl = 0; m_op_a = 0; m_op_b = 0; m_imm = 0; m_pc = 0;
        m_cnt = 0;
    endtask

    // Producers listed youngest first; the first one writing s decides.
    task automatic model_src(input logic use_s, input logic [4:0] s, input logic [XLEN-1:0] rdata,
                             output logic [XLEN-1:0] op, output logic fwd, output logic haz);
        prod_t p[3];
        p[0] = '{m_valid && m_rw && (m_rd == s), m_mr, !m_mr, '0};
        p[1] = '{mem_wen && (mem_rd == s), !mem_data_valid, 1'b0, mem_data};
        p[2] = '{wb_wen && (wb_rd == s), 1'b0, 1'b0, wb_data};
        op = '0; fwd = 0; haz = 0;
        if (!use_s || s == 5'd0) return;
        op = rdata;
        for (int k = 0; k < 3; k++) begin
            if (p[k].hit) begin
                haz = p[k].stall;
                fwd = p[k].fwd;
                op  = (p[k].stall || p[k].fwd) ? '0 : p[k].val;
                break;
            end
        end
    endtask

    task automatic check_reset();
        chk("rst_valid", ex_valid, 0);   chk("rst_op_a", ex_op_a, 0);
        chk("rst_op_b", ex_op_b, 0);     chk("rst_fwd_a", ex_fwd_a, 0);
        chk("rst_fwd_b", ex_fwd_b, 0);   chk("rst_rd", ex_rd, 0);
        chk("rst_rw", ex_reg_write, 0);  chk("rst_mr", ex_mem_read, 0);
        chk("rst_ctrl", ex_ctrl, 0);     chk("rst_imm", ex_imm, 0);
        chk("rst_pc", ex_pc, 0);         chk("rst_stall_cnt", stall_cnt, 0);
    endtask

    task automatic check_outputs();
        chk("ex_valid", ex_valid, m_valid);
        chk("stall_cnt", stall_cnt, m_cnt);
        if (m_valid) begin
            chk("ex_op_a", ex_op_a, m_op_a);        chk("ex_op_b", ex_op_b, m_op_b);
            chk("ex_fwd_a", ex_fwd_a, m_fwd_a);     chk("ex_fwd_b", ex_fwd_b, m_fwd_b);
            chk("ex_rd", ex_rd, m_rd);              chk("ex_reg_write", ex_reg_write, m_rw);
            chk("ex_mem_read", ex_mem_read, m_mr);  chk("ex_ctrl", ex_ctrl, m_ctrl);
            chk("ex_imm", ex_imm, m_imm);           chk("ex_pc", ex_pc, m_pc);
        end
    endtask

    // Called just after an edge with inputs already applied; ends just after the next edge.
    task automatic cycle();
        logic [XLEN-1:0] oa, ob;
        logic fa, fb, ha, hb, haz, adv;
        #1;
        model_src(id_use_rs1, id_rs1, rf_rdata1, oa, fa, ha);
        model_src(id_use_rs2, id_rs2, rf_rdata2, ob, fb, hb);
        haz = id_valid && (ha || hb);
        adv = !m_valid || ex_ready;
        chk("id_ready", id_ready, flush || (adv && !haz));
        chk("rf_rs1", rf_rs1, id_rs1);
        chk("rf_rs2", rf_rs2, id_rs2);
        if (flush) begin
            m_valid = 0;
        end else if (adv) begin
            m_valid = id_valid && !haz;
            if (m_valid) begin
                m_op_a = oa; m_op_b = ob; m_fwd_a = fa; m_fwd_b = fb;
                m_rd = id_rd; m_rw = id_reg_write; m_mr = id_mem_read;
                m_ctrl = id_ctrl; m_imm = id_imm; m_pc = id_pc;
            end
        end
`ifdef ID_EX_STALL_COUNTER_EN
        if (haz && !flush) m_cnt = m_cnt + 32'd1;
`endif
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic idle();
        id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
        id_rd = 0; id_reg_write = 0; id_mem_read = 0;
        id_ctrl = 8'h5A; id_imm = 32'h1000; id_pc = 32'h2000;
        rf_rdata1 = 32'hDEAD_0001; rf_rdata2 = 32'hDEAD_0002;
        wb_wen = 0; wb_rd = 0; wb_data = 0;
        mem_wen = 0; mem_rd = 0; mem_data_valid = 0; mem_data = 0;
        flush = 0; ex_ready = 1;
    endtask

    task automatic issue_load(input logic [4:0] rd);
        idle();
        id_valid = 1; id_rd = rd; id_reg_write = 1; id_mem_read = 1;
        cycle();
    endtask

    initial begin
        idle();
        model_reset();
        rst_n = 0;
        #2;
        check_reset();
        @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        #1;

        // WB bypass: register file still shows the old value.
        idle();
        id_valid = 1; id_use_rs1 = 1; id_rs1 = 5; rf_rdata1 = 7;
        wb_wen = 1; wb_rd = 5; wb_data = 9;
        cycle();
        chk("wb_bypass", ex_op_a, 9);

        // Load-use: one bubble, then MEM data forwarded.
        issue_load(5'd3);
        idle();
        id_valid = 1; id_use_rs1 = 1; id_rs1 = 3;
        #1 chk("lu_id_ready", id_ready, 0);
        cycle();
        chk("lu_bubble", ex_valid, 0);
        mem_wen = 1; mem_rd = 3; mem_data_valid = 1; mem_data = 32'h55;
        cycle();
        chk("lu_op_a", ex_op_a, 32'h55);
`ifdef ID_EX_STALL_COUNTER_EN
        chk("lu_stall_cnt", stall_cnt, 1);
`endif

        // ALU back-to-back: EX-ahead flag, no stall.
        idle();
        id_valid = 1; id_rd = 4; id_reg_write = 1;
        cycle();
        idle();
        id_valid = 1; id_use_rs2 = 1; id_rs2 = 4; rf_rdata2 = 32'h1234;
        #1 chk("alu_id_ready", id_ready, 1);
        cycle();
        chk("alu_fwd_b", ex_fwd_b, 1);
        chk("alu_op_b", ex_op_b, 0);

        // MEM beats WB.
        idle();
        id_valid = 1; id_use_rs1 = 1; id_rs1 = 6;
        mem_wen = 1; mem_rd = 6; mem_data_valid = 1; mem_data = 32'hA;
        wb_wen = 1; wb_rd = 6; wb_data = 32'hB;
        cycle();
        chk("prio_mem_over_wb", ex_op_a, 32'hA);

        // x0 is never forwarded.
        idle();
        id_valid = 1; id_use_rs1 = 1; id_rs1 = 0; rf_rdata1 = 32'h77;
        wb_wen = 1; wb_rd = 0; wb_data = 32'hFFFF;
        mem_wen = 1; mem_rd = 0; mem_data_valid = 1; mem_data = 32'h1;
        cycle();
        chk("x0_op_a", ex_op_a, 0);

        // Backpressure for three cycles, then flush during the hold.
        idle();
        id_valid = 1; id_use_rs1 = 1; id_rs1 = 9; id_pc = 32'h300; ex_ready = 0;
        for (int i = 0; i < 3; i++) begin
            #1 chk("bp_id_ready", id_ready, 0);
            cycle();
            chk("bp_hold_op_a", ex_op_a, 0);
            chk("bp_hold_valid", ex_valid, 1);
        end
        flush = 1;
        #1 chk("flush_id_ready", id_ready, 1);
        cycle();
        chk("flush_valid", ex_valid, 0);

        // Reset asserted in the middle of a stall acts without a clock edge.
        issue_load(5'd7);
        idle();
        id_valid = 1; id_use_rs1 = 1; id_rs1 = 7;
        cycle();
        mem_wen = 1; mem_rd = 7; mem_data_valid = 0;
        cycle();
        #2 rst_n = 0;
        #1 check_reset();
        model_reset();
        idle();
        @(negedge clk);
        rst_n = 1;
        cycle();

        // Random traffic over a small register window to provoke matches.
        for (int n = 0; n < 400; n++) begin
            id_valid       = ($urandom_range(0, 3) != 0);
            id_rs1         = 5'($urandom_range(0, 7));
            id_rs2         = 5'($urandom_range(0, 7));
            id_use_rs1     = 1'($urandom);
            id_use_rs2     = 1'($urandom);
            id_rd          = 5'($urandom_range(0, 7));
            id_reg_write   = 1'($urandom);
            id_mem_read    = ($urandom_range(0, 2) == 0);
            id_ctrl        = 8'($urandom);
            id_imm         = $urandom;
            id_pc          = $urandom;
            rf_rdata1      = $urandom;
            rf_rdata2      = $urandom;
            wb_wen         = 1'($urandom);
            wb_rd          = 5'($urandom_range(0, 7));
            wb_data        = $urandom;
            mem_wen        = 1'($urandom);
            mem_rd         = 5'($urandom_range(0, 7));
            mem_data_valid = 1'($urandom);
            mem_data       = $urandom;
            flush          = ($urandom_range(0, 15) == 0);
            ex_ready       = ($urandom_range(0, 9) < 7);
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
